// File: rtl/fir_coef_loader.sv
// Runtime coefficient loader: serial beats fill a shadow bank, which is committed
// atomically to the active bank, then filter output-valid is masked for one pipeline flush.
module fir_coef_loader #(
    parameter int unsigned FILT_DEPTH   = 64,
    parameter int unsigned COEF_WIDTH   = 16,
    parameter int unsigned FLUSH_CYCLES = FILT_DEPTH + 6
) (
    input  logic                                  clk_main,
    input  logic                                  rst_n,
    input  logic [COEF_WIDTH-1:0]                 coef_in,
    input  logic                                  coef_vld,
    input  logic                                  coef_last,
    output logic                                  coef_rdy,
    output logic [(FILT_DEPTH/2)*COEF_WIDTH-1:0]  coefs_out,
    output logic                                  coef_swap,
    input  logic                                  outdata_vld_in,
    output logic                                  outdata_vld_out,
    output logic                                  busy,
    output logic                                  load_err
);

    localparam int unsigned N       = FILT_DEPTH / 2;
    localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned BANK_W  = N * COEF_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_DISCARD = 3'd2;
    localparam logic [2:0] ST_COMMIT  = 3'd3;
    localparam logic [2:0] ST_FLUSH   = 3'd4;

    logic [2:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [FLUSH_W-1:0] flush_cnt, flush_d;
    logic               err_d, swap_d, rdy_d, busy_d;
    logic               shadow_we, bank_load;
    logic [CNT_W-1:0]   shadow_idx;
    logic [BANK_W-1:0]  shadow;
    logic               accept;

    assign accept = coef_vld & coef_rdy;

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        flush_d    = flush_cnt;
        err_d      = 1'b0;
        swap_d     = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = cnt;
        bank_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shadow_we  = 1'b1;
                    shadow_idx = '0;
                    cnt_d      = CNT_W'(1);
                    if (coef_last) err_d = 1'b1;
                    else           state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        cnt_d = '0;
                        if (coef_last) begin
                            state_d = ST_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else if (coef_last) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DISCARD: begin
                if (accept && coef_last) state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                bank_load = 1'b1;
                swap_d    = 1'b1;
                flush_d   = FLUSH_W'(FLUSH_CYCLES);
                state_d   = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt <= FLUSH_W'(1)) begin
                    flush_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_cnt - FLUSH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DISCARD);
        busy_d = (state_d != ST_IDLE);
    end

    // Control state; coef_rdy is held low through reset and rises one cycle after release
    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            flush_cnt <= '0;
            load_err  <= 1'b0;
            coef_swap <= 1'b0;
            coef_rdy  <= 1'b0;
            busy      <= 1'b0;
            coefs_out <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            flush_cnt <= flush_d;
            load_err  <= err_d;
            coef_swap <= swap_d;
            coef_rdy  <= rdy_d;
            busy      <= busy_d;
            if (bank_load) coefs_out <= shadow;
        end
    end

    // Shadow bank: contents are meaningless until a well-formed load completes
    always_ff @(posedge clk_main) begin
        for (int h = 0; h < int'(N); h++) begin
            if (shadow_we && shadow_idx == CNT_W'(h))
                shadow[h*COEF_WIDTH +: COEF_WIDTH] <= coef_in;
        end
    end

    assign outdata_vld_out = outdata_vld_in & ~((state == ST_COMMIT) | (state == ST_FLUSH));

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader at FILT_DEPTH=8; committed banks are checked
// against a scoreboard queue as coef_swap fires.
module tb_fir_coef_loader;

    localparam int unsigned FD = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned FC = FD + 6;
    localparam int unsigned NB = FD / 2;
    localparam int unsigned BW = NB * CW;

    logic          clk_main = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] coef_in = '0;
    logic          coef_vld = 1'b0;
    logic          coef_last = 1'b0;
    logic          coef_rdy;
    logic [BW-1:0] coefs_out;
    logic          coef_swap;
    logic          outdata_vld_in = 1'b1;
    logic          outdata_vld_out;
    logic          busy;
    logic          load_err;

    int total = 0;
    int bad = 0;
    int swaps = 0;
    int errs = 0;
    logic [BW-1:0] exp_q[$];

    fir_coef_loader #(.FILT_DEPTH(FD), .COEF_WIDTH(CW), .FLUSH_CYCLES(FC)) dut (
        .clk_main(clk_main), .rst_n(rst_n), .coef_in(coef_in), .coef_vld(coef_vld),
        .coef_last(coef_last), .coef_rdy(coef_rdy), .coefs_out(coefs_out),
        .coef_swap(coef_swap), .outdata_vld_in(outdata_vld_in),
        .outdata_vld_out(outdata_vld_out), .busy(busy), .load_err(load_err)
    );

    always #5 clk_main = ~clk_main;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each swap pops the bank expected from the matching load
    always @(negedge clk_main) begin
        if (rst_n && coef_swap) begin
            swaps++;
            if (exp_q.size() == 0) chk("unexpected_swap", BW'(1), BW'(0));
            else                   chk("bank_on_swap", coefs_out, exp_q.pop_front());
        end
        if (rst_n && load_err === 1'b1) errs++;
    end

    // Offer one beat and hold it until accepted, then leave gap idle cycles
    task automatic send(input logic [CW-1:0] d, input logic last, input int gap);
        int  n = 0;
        logic acc = 1'b0;
        coef_vld  = 1'b1;
        coef_in   = d;
        coef_last = last;
        while (!acc && n < 50) begin
            @(negedge clk_main);
            acc = coef_rdy;
            @(posedge clk_main);
            n++;
        end
        #1;
        coef_vld  = 1'b0;
        coef_last = 1'b0;
        if (!acc) chk("beat_accept_timeout", BW'(0), BW'(1));
        repeat (gap) begin
            @(posedge clk_main);
            #1;
        end
    endtask

    // Count cycles with rdy low and output-valid masked after a committing beat
    task automatic measure_flush(input string tag);
        int  n = 0;
        logic all_masked = 1'b1;
        @(negedge clk_main);
        while (!coef_rdy && n < 100) begin
            n++;
            if (outdata_vld_out !== 1'b0) all_masked = 1'b0;
            @(negedge clk_main);
        end
        chk({tag, "_rdy_low_cycles"}, BW'(n), BW'(FC + 1));
        chk({tag, "_vld_masked"}, BW'(all_masked), BW'(1));
        chk({tag, "_vld_restored"}, BW'(outdata_vld_out), BW'(1));
        chk({tag, "_idle_after"}, BW'(busy), BW'(0));
    endtask

    function automatic logic [BW-1:0] bank4(input int a, input int b, input int c, input int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] bank_a;
        bank_a = bank4(1, 2, 3, 4);

        // Reset held with a pending beat
        rst_n = 1'b0;
        coef_vld = 1'b1;
        repeat (3) @(posedge clk_main);
        @(negedge clk_main);
        chk("rst_rdy", BW'(coef_rdy), BW'(0));
        chk("rst_bank", coefs_out, BW'(0));
        chk("rst_swap", BW'(coef_swap), BW'(0));
        chk("rst_err", BW'(load_err), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_vld_pass", BW'(outdata_vld_out), BW'(1));
        @(posedge clk_main); #1;
        rst_n = 1'b1;
        coef_vld = 1'b0;
        @(posedge clk_main);
        @(negedge clk_main);
        chk("release_rdy", BW'(coef_rdy), BW'(1));

        // Nominal back-to-back load
        @(posedge clk_main); #1;
        send(CW'(1), 1'b0, 0);
        send(CW'(2), 1'b0, 0);
        send(CW'(3), 1'b0, 0);
        exp_q.push_back(bank_a);
        send(CW'(4), 1'b1, 0);
        measure_flush("nominal");
        chk("nominal_swaps", BW'(swaps), BW'(1));
        chk("nominal_bank_held", coefs_out, bank_a);

        // Early last on beat index 1
        @(posedge clk_main); #1;
        send(CW'(7), 1'b0, 0);
        send(CW'(9), 1'b1, 0);
        @(negedge clk_main);
        chk("early_err", BW'(load_err), BW'(1));
        chk("early_busy", BW'(busy), BW'(0));
        chk("early_bank", coefs_out, bank_a);
        @(negedge clk_main);
        chk("early_err_pulse", BW'(load_err), BW'(0));

        // Missing last: error after beat 4, beats 5-6 discarded
        @(posedge clk_main); #1;
        send(CW'(21), 1'b0, 0);
        send(CW'(22), 1'b0, 0);
        send(CW'(23), 1'b0, 0);
        send(CW'(24), 1'b0, 0);
        @(negedge clk_main);
        chk("miss_err", BW'(load_err), BW'(1));
        chk("miss_busy", BW'(busy), BW'(1));
        @(posedge clk_main); #1;
        send(CW'(25), 1'b0, 0);
        send(CW'(26), 1'b1, 0);
        @(negedge clk_main);
        chk("miss_idle", BW'(busy), BW'(0));
        chk("miss_no_err", BW'(load_err), BW'(0));
        chk("miss_bank", coefs_out, bank_a);
        chk("miss_no_swap", BW'(swaps), BW'(1));
        chk("err_count", BW'(errs), BW'(2));

        // Throttled source with two idle cycles between beats
        @(posedge clk_main); #1;
        send(CW'(1), 1'b0, 2);
        send(CW'(2), 1'b0, 2);
        send(CW'(3), 1'b0, 2);
        exp_q.push_back(bank_a);
        send(CW'(4), 1'b1, 0);
        measure_flush("throttled");
        chk("throttled_swaps", BW'(swaps), BW'(2));

        // Reset mid-load, then a fresh full load
        @(posedge clk_main); #1;
        send(CW'(11), 1'b0, 0);
        send(CW'(12), 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk_main); #1;
        rst_n = 1'b1;
        @(negedge clk_main);
        chk("midrst_bank", coefs_out, BW'(0));
        chk("midrst_busy", BW'(busy), BW'(0));
        @(posedge clk_main); #1;
        send(CW'(5), 1'b0, 0);
        send(CW'(6), 1'b0, 0);
        send(CW'(7), 1'b0, 0);
        exp_q.push_back(bank4(5, 6, 7, 8));
        send(CW'(8), 1'b1, 0);
        measure_flush("postrst");
        chk("postrst_bank", coefs_out, bank4(5, 6, 7, 8));
        chk("final_swaps", BW'(swaps), BW'(3));
        chk("final_errs", BW'(errs), BW'(2));
        chk("scoreboard_drained", BW'(exp_q.size()), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
